// File: rtl/fir_mac_engine_pkg.sv
// Shared FIR definitions: default geometry, MAC controller state encoding and
// a lane-offset helper for flattened tap/coefficient buses.
package fir_mac_engine_pkg;

  localparam int DEF_TAPS = 8;
  localparam int DEF_DW   = 10;
  localparam int DEF_CW   = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_e;

  function automatic int lane_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Single signed multiplier feeding an accumulator register with
// synchronous clear and accumulate enable.
module fir_mac_unit #(
  parameter int DW = 10,
  parameter int CW = 10,
  parameter int AW = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    acc_d;
  logic signed [AW-1:0]    acc_q;

  assign prod = a * b;

  // Clear wins over enable so a new computation always starts from zero.
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + AW'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_mac_engine.sv
// Time-multiplexed FIR MAC: snapshots taps and coefficients on start, then
// accumulates one tap product per cycle and publishes the sum.
module fir_mac_engine
  import fir_mac_engine_pkg::*;
#(
  parameter int TAPS = DEF_TAPS,
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int AW   = DW + CW + $clog2(TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [TAPS*DW-1:0]     tap_data,
  input  logic [TAPS*CW-1:0]     coef,
  output logic                   busy,
  output logic                   out_valid,
  output logic signed [AW-1:0]   out_data,
  output logic                   overrun
);

  localparam int IW = $clog2(TAPS);

  state_e               state_d, state_q;
  logic [IW-1:0]        idx_d, idx_q;
  logic [TAPS*DW-1:0]   tap_snap_d, tap_snap_q;
  logic [TAPS*CW-1:0]   coef_snap_d, coef_snap_q;
  logic signed [AW-1:0] out_data_d, out_data_q;
  logic                 out_valid_d, out_valid_q;
  logic                 overrun_d, overrun_q;
  logic                 mac_clear, mac_en;
  logic signed [DW-1:0] tap_sel;
  logic signed [CW-1:0] coef_sel;
  logic signed [AW-1:0] acc;

  assign tap_sel  = tap_snap_q[lane_lsb(int'(idx_q), DW) +: DW];
  assign coef_sel = coef_snap_q[lane_lsb(int'(idx_q), CW) +: CW];

  fir_mac_unit #(
    .DW(DW),
    .CW(CW),
    .AW(AW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clear(mac_clear),
    .en   (mac_en),
    .a    (tap_sel),
    .b    (coef_sel),
    .acc  (acc)
  );

  // DONE shares the IDLE accept path so start in DONE gives back-to-back runs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tap_snap_d  = tap_snap_q;
    coef_snap_d = coef_snap_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    overrun_d   = 1'b0;
    mac_clear   = 1'b0;
    mac_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tap_snap_d  = tap_data;
          coef_snap_d = coef;
          mac_clear   = 1'b1;
          idx_d       = '0;
          state_d     = ST_ACC;
        end
      end
      ST_ACC: begin
        mac_en    = 1'b1;
        overrun_d = start;
        if (idx_q == IW'(TAPS - 1)) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        out_data_d  = acc;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
        if (start) begin
          tap_snap_d  = tap_data;
          coef_snap_d = coef;
          mac_clear   = 1'b1;
          idx_d       = '0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tap_snap_q  <= '0;
      coef_snap_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tap_snap_q  <= tap_snap_d;
      coef_snap_q <= coef_snap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule
